layer_buffer_dp: RTL and testbench

//  Parametrised true dual-port layer buffer for CNN feature-map storage. It generalises the fixed 208x128

---
 rtl/layer_buffer_dp.sv | 175 +++++++++++++++++
 tb/tb_layer_buffer_dp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/layer_buffer_dp.sv
// rtl/layer_buffer_dp.sv - true dual-port CNN layer buffer with collision policy and clear sweep
module layer_buffer_dp #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 208,
  parameter int ADDR_W = 8
) (
  input  logic              CK,
  input  logic              rst,
  input  logic              clear_start,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              wr_collision
);

  // DEPTH widened by one bit so a full 2**ADDR_W depth still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Storage: deliberately not reset, software requests a clear sweep instead.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;

  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              wr_collision_q, wr_collision_d;

  logic              acc_a, acc_b;
  logic              a_in_range, b_in_range;
  logic              a_wr, b_wr, a_rd, b_rd;
  logic              same_addr;
  logic              b_wr_drop;

  // Request qualification: nothing is accepted while the sweep owns the array.
  always_comb begin
    acc_a      = a_en && !busy_q;
    acc_b      = b_en && !busy_q;
    a_in_range = ({1'b0, a_addr} < DEPTH_W);
    b_in_range = ({1'b0, b_addr} < DEPTH_W);
    a_wr       = acc_a && a_we;
    b_wr       = acc_b && b_we;
    a_rd       = acc_a && !a_we;
    b_rd       = acc_b && !b_we;
    same_addr  = (a_addr == b_addr);
    // Port A wins a same-address write race; B's write is discarded.
    b_wr_drop  = a_wr && b_wr && same_addr && a_in_range;
  end

  // Port A read path: out-of-range reads return zero, a same-cycle B write is forwarded.
  always_comb begin
    a_rdata_d  = a_rdata_q;
    a_rvalid_d = a_rd;
    if (a_rd) begin
      if (!a_in_range) begin
        a_rdata_d = '0;
      end else if (b_wr && same_addr) begin
        a_rdata_d = b_wdata;
      end else begin
        a_rdata_d = mem_q[a_addr];
      end
    end
  end

  // Port B read path: mirror of port A, forwarding a same-cycle A write.
  always_comb begin
    b_rdata_d  = b_rdata_q;
    b_rvalid_d = b_rd;
    if (b_rd) begin
      if (!b_in_range) begin
        b_rdata_d = '0;
      end else if (a_wr && same_addr) begin
        b_rdata_d = a_wdata;
      end else begin
        b_rdata_d = mem_q[b_addr];
      end
    end
  end

  // Collision flag is raised the cycle after B's write is dropped.
  always_comb begin
    wr_collision_d = b_wr_drop;
  end

  // Array writes: sweep zeros while clearing, otherwise B then A so A overrides on a tie.
  always_ff @(posedge CK) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      if (b_wr && b_in_range && !b_wr_drop) begin
        mem_q[b_addr] <= b_wdata;
      end
      if (a_wr && a_in_range) begin
        mem_q[a_addr] <= a_wdata;
      end
    end
  end

  // Clear sweep controller: one word per cycle, busy spans exactly DEPTH cycles.
  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          clr_ptr_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Registered read data, valid pulses and collision flag.
  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
      a_rvalid_q     <= 1'b0;
      b_rvalid_q     <= 1'b0;
      wr_collision_q <= 1'b0;
    end else begin
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
      a_rvalid_q     <= a_rvalid_d;
      b_rvalid_q     <= b_rvalid_d;
      wr_collision_q <= wr_collision_d;
    end
  end

  assign busy         = busy_q;
  assign a_rdata      = a_rdata_q;
  assign a_rvalid     = a_rvalid_q;
  assign b_rdata      = b_rdata_q;
  assign b_rvalid     = b_rvalid_q;
  assign wr_collision = wr_collision_q;

endmodule

// File: tb/tb_layer_buffer_dp.sv
// tb/tb_layer_buffer_dp.sv - directed scoreboard bench for layer_buffer_dp
module tb_layer_buffer_dp;

  localparam int DW = 128;
  localparam int DP = 208;
  localparam int AW = 8;

  logic          CK = 1'b0;
  logic          rst;
  logic          clear_start;
  logic          busy;
  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;
  logic          wr_collision;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [DP];
  logic          m_busy;
  int            m_ptr;
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] last_a, last_b;
  logic          exp_col;

  layer_buffer_dp #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .CK(CK), .rst(rst), .clear_start(clear_start), .busy(busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .wr_collision(wr_collision)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, update the reference model, clock, then compare.
  task automatic step(input logic cs,
                      input logic ae, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic be, input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic acc_a, acc_b, a_ok, b_ok;
    clear_start = cs;
    a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
    b_en = be; b_we = bwe; b_addr = ba; b_wdata = bd;
    acc_a = ae && !m_busy;
    acc_b = be && !m_busy;
    a_ok  = (int'(aa) < DP);
    b_ok  = (int'(ba) < DP);
    if (acc_a && !awe)
      exp_a.push_back(!a_ok ? '0 : (acc_b && bwe && ba == aa) ? bd : model[aa]);
    if (acc_b && !bwe)
      exp_b.push_back(!b_ok ? '0 : (acc_a && awe && ba == aa) ? ad : model[ba]);
    exp_col = acc_a && acc_b && awe && bwe && (aa == ba) && a_ok;
    if (m_busy) model[m_ptr] = '0;
    if (acc_b && bwe && b_ok && !exp_col) model[ba] = bd;
    if (acc_a && awe && a_ok) model[aa] = ad;
    if (m_busy) begin
      if (m_ptr == DP - 1) m_busy = 1'b0;
      else m_ptr++;
    end else if (cs) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end
    @(posedge CK);
    #1;
    chk("busy", DW'(busy), DW'(m_busy));
    chk("wr_collision", DW'(wr_collision), DW'(exp_col));
    chk("a_rvalid", DW'(a_rvalid), DW'(exp_a.size() > 0));
    chk("b_rvalid", DW'(b_rvalid), DW'(exp_b.size() > 0));
    if (exp_a.size() > 0) last_a = exp_a.pop_front();
    if (exp_b.size() > 0) last_b = exp_b.pop_front();
    chk("a_rdata", a_rdata, last_a);
    chk("b_rdata", b_rdata, last_b);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, ad, d, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic a_read(input logic [AW-1:0] ad);
    step(1'b0, 1'b1, 1'b0, ad, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int cnt;
    int guard;
    for (int i = 0; i < DP; i++) model[i] = 'x;
    m_busy = 1'b0; m_ptr = 0; last_a = '0; last_b = '0; exp_col = 1'b0;
    rst = 1'b1; clear_start = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge CK);
    #1;
    chk("reset_busy", DW'(busy), '0);
    chk("reset_a_rdata", a_rdata, '0);
    chk("reset_b_rdata", b_rdata, '0);
    chk("reset_rvalid", DW'({a_rvalid, b_rvalid}), '0);
    chk("reset_collision", DW'(wr_collision), '0);
    @(negedge CK);
    rst = 1'b0;

    // 1: full clear sweep, busy counted, then reads of cleared words
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    cnt = busy ? 1 : 0;
    guard = 0;
    while (busy === 1'b1 && guard < 300) begin
      idle();
      if (busy === 1'b1) cnt++;
      guard++;
    end
    chk("busy_cycles", DW'(cnt), DW'(DP));
    a_read(8'd0);
    a_read(8'd5);
    a_read(8'd207);
    idle();

    // 2: write then read on A; B stays quiet
    a_write(8'd10, {16{8'hAA}});
    a_read(8'd10);
    idle();

    // 3: W/W collision, A wins
    step(1'b0, 1'b1, 1'b1, 8'd20, DW'(8'h11), 1'b1, 1'b1, 8'd20, DW'(8'h22));
    idle();
    a_read(8'd20);
    idle();

    // 4: A write, B read same address -> write-first forwarding
    step(1'b0, 1'b1, 1'b1, 8'd30, DW'(8'h33), 1'b1, 1'b0, 8'd30, '0);
    idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'd30, '0);
    // R/R same address
    step(1'b0, 1'b1, 1'b0, 8'd10, '0, 1'b1, 1'b0, 8'd10, '0);
    idle();

    // 5: out-of-range write and read, then the whole array is unchanged
    a_write(8'd208, {4{32'hDEADBEEF}});
    a_read(8'd208);
    a_write(8'd255, {4{32'hCAFEF00D}});
    step(1'b0, 1'b1, 1'b0, 8'd255, '0, 1'b1, 1'b0, 8'd209, '0);
    for (int i = 0; i < DP; i++) a_read(AW'(i));
    idle();

    // 6: seed words, start clear, reset at sweep cycle 50
    a_write(8'd5, DW'(8'h55));
    a_write(8'd49, DW'(8'h49));
    a_write(8'd100, {8{16'h1234}});
    step(1'b1, 1'b1, 1'b0, 8'd100, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) step(1'b0, 1'b1, 1'b0, 8'd100, '0, 1'b1, 1'b1, 8'd60, DW'(8'h77));
      else if (i == 20) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      else idle();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", DW'(busy), '0);
    chk("abort_a_rvalid", DW'(a_rvalid), '0);
    chk("abort_a_rdata", a_rdata, '0);
    m_busy = 1'b0; m_ptr = 0; last_a = '0; last_b = '0;
    exp_a.delete(); exp_b.delete();
    @(negedge CK);
    rst = 1'b0;
    a_read(8'd0);
    a_read(8'd5);
    a_read(8'd49);
    a_read(8'd100);
    step(1'b0, 1'b1, 1'b0, 8'd50, '0, 1'b1, 1'b0, 8'd60, '0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
